buffer_window_reader: RTL and testbench

- Read-side companion to the team's parallel circular buffer.
- Drains the buffer through its valid/read_en interface, PAR_READ elements per read.
- Packs the elements into WINDOW-element windows and hands each window to a downstream compute stage over a valid/ready handshake.
- Consumes a programmed number of windows per start, then signals done.

---
 rtl/buffer_window_reader_if.sv | 23 ++
 rtl/buffer_window_reader.sv | 100 ++++++++++
 tb/tb_buffer_window_reader.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/buffer_window_reader_if.sv
// Buffer-read and window-output handshakes for buffer_window_reader.
// master = the reader block; slave = buffer plus downstream consumer.
interface buffer_window_reader_if #(
  parameter int PAR_READ = 1,
  parameter int BITS     = 16,
  parameter int WINDOW   = 4
);
  logic                     buf_valid;
  logic [BITS*PAR_READ-1:0] buf_dout;
  logic                     buf_read_en;
  logic [BITS*WINDOW-1:0]   win_data;
  logic                     win_valid;
  logic                     win_ready;

  modport master (
    input  buf_valid, buf_dout, win_ready,
    output buf_read_en, win_data, win_valid
  );
  modport slave (
    output buf_valid, buf_dout, win_ready,
    input  buf_read_en, win_data, win_valid
  );
endinterface

// File: rtl/buffer_window_reader.sv
// Drains a parallel circular buffer into WINDOW-element windows, `length` windows per start.
// Optional macro SLIDING_WINDOW_EN: consecutive windows overlap with stride PAR_READ.
module buffer_window_reader #(
  parameter int PAR_READ = 1,
  parameter int BITS     = 16,
  parameter int WINDOW   = 4,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       length,
  output logic                   busy,
  output logic                   done,
  buffer_window_reader_if.master bus
);
  localparam int FW = $clog2(WINDOW + 1);
  localparam logic [FW-1:0] STEP = FW'(PAR_READ);
  localparam logic [FW-1:0] FULL = FW'(WINDOW);
`ifdef SLIDING_WINDOW_EN
  // Keep the window; one more read yields the next overlapping window.
  localparam logic [FW-1:0] REFILL = FW'(WINDOW - PAR_READ);
`else
  localparam logic [FW-1:0] REFILL = '0;
`endif

  typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} state_t;

  state_t                 state;
  logic [BITS*WINDOW-1:0] window;
  logic [BITS*WINDOW-1:0] shifted;
  logic [FW-1:0]          fill;
  logic [CNT_W-1:0]       remaining;
  logic                   win_valid_q;

  assign bus.buf_read_en = (state == FILL) && bus.buf_valid;
  assign bus.win_data    = window;
  assign bus.win_valid   = win_valid_q;

  // New elements enter at the top so element 0 ends up the oldest.
  generate
    if (WINDOW == PAR_READ) begin : g_full
      assign shifted = bus.buf_dout;
    end else begin : g_shift
      assign shifted = {bus.buf_dout, window[BITS*WINDOW-1:BITS*PAR_READ]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      window      <= '0;
      fill        <= '0;
      remaining   <= '0;
      win_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          if (length != '0) begin
            remaining <= length;
            fill      <= '0;
            state     <= FILL;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        FILL: if (bus.buf_read_en) begin
          window <= shifted;
          fill   <= fill + STEP;
          if (fill + STEP == FULL) begin
            win_valid_q <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: if (bus.win_ready) begin
          win_valid_q <= 1'b0;
          remaining   <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            fill  <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            fill  <= REFILL;
            state <= FILL;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_buffer_window_reader.sv
// Randomized bench for buffer_window_reader: PAR_READ=1 and PAR_READ=2 instances
// checked against a window/read-count model derived from the element stream.
module tb_buffer_window_reader;
  localparam int BITS = 16;
  localparam int W    = 4;
`ifdef SLIDING_WINDOW_EN
  localparam bit SLIDE = 1'b1;
`else
  localparam bit SLIDE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buffer_window_reader_if #(.PAR_READ(1), .BITS(BITS), .WINDOW(W)) bus1();
  buffer_window_reader_if #(.PAR_READ(2), .BITS(BITS), .WINDOW(W)) bus2();

  logic        start1, busy1, done1;
  logic [15:0] len1;
  logic        start2, busy2, done2;
  logic [3:0]  len2;

  buffer_window_reader #(.PAR_READ(1), .BITS(BITS), .WINDOW(W), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .length(len1),
    .busy(busy1), .done(done1), .bus(bus1.master));

  buffer_window_reader #(.PAR_READ(2), .BITS(BITS), .WINDOW(W), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .length(len2),
    .busy(busy2), .done(done2), .bus(bus2.master));

  int n_chk  = 0;
  int n_fail = 0;
  logic [BITS-1:0] data[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: reads needed, windows available after r reads, window contents.
  function automatic int exp_reads(input int len, input int p);
    if (len == 0) return 0;
    return SLIDE ? (W/p + len - 1) : len * (W/p);
  endfunction

  function automatic int avail(input int r, input int p);
    int n = W / p;
    if (SLIDE) return (r >= n) ? r - n + 1 : 0;
    return r / n;
  endfunction

  function automatic logic [63:0] exp_win(input int k, input int p);
    logic [63:0] res = '0;
    int base = SLIDE ? k * p : k * W;
    for (int i = 0; i < W; i++) res[i*BITS +: BITS] = data[base + i];
    return res;
  endfunction

  // mode: 0 random data, 1 data 1,2,3..., 2 data 10,20,30...
  task automatic job1(input int len, input int vpct, input int rpct, input logic [15:0] vpat,
                      input int vpat_n, input int stall_n, input int restart_at,
                      input int mode, input string nm);
    int  ptr = 0, reads = 0, k = 0, cyc = 0, stall_left = stall_n;
    bit  finished = 0, rd, acc, exp_v;
    data.delete();
    for (int i = 0; i < exp_reads(len, 1) + 4; i++)
      data.push_back(mode == 1 ? BITS'(i + 1) : mode == 2 ? BITS'(10 * (i + 1)) : BITS'($urandom));
    start1 = 1'b1; len1 = len[15:0];
    bus1.buf_valid = 1'b0; bus1.win_ready = 1'b0;
    @(posedge clk); #1 start1 = 1'b0;
    while (cyc < 400) begin
      start1 = 1'b0;
      if (cyc < vpat_n) bus1.buf_valid = vpat[cyc] && (ptr < data.size());
      else bus1.buf_valid = (ptr < data.size()) && ($urandom_range(99) < vpct);
      bus1.buf_dout  = (ptr < data.size()) ? data[ptr] : '0;
      bus1.win_ready = ($urandom_range(99) < rpct);
      if (bus1.win_valid && stall_left > 0) begin bus1.win_ready = 1'b0; stall_left--; end
      if (cyc == restart_at) begin start1 = 1'b1; len1 = 16'd9; end
      @(negedge clk);
      exp_v = (avail(reads, 1) > k) && (k < len);
      chk({nm, " win_valid"}, bus1.win_valid, exp_v);
      chk({nm, " rd_en"}, bus1.buf_read_en, bus1.buf_valid && !exp_v && reads < exp_reads(len, 1));
      chk({nm, " busy"}, busy1, 1'b1);
      if (exp_v) chk({nm, " win_data"}, bus1.win_data, exp_win(k, 1));
      chk({nm, " done"}, done1, k == len);
      if (k == len) begin finished = 1; break; end
      rd  = bus1.buf_read_en;
      acc = bus1.win_valid && bus1.win_ready;
      @(posedge clk); #1;
      if (rd) begin ptr++; reads++; end
      if (acc) k++;
      cyc++;
    end
    if (!finished) chk({nm, " timeout"}, 1'b0, 1'b1);
    chk({nm, " reads"}, reads, exp_reads(len, 1));
    @(posedge clk); #1 start1 = 1'b0; bus1.buf_valid = 1'b0;
    @(negedge clk);
    chk({nm, " done_low"}, done1, 1'b0);
    chk({nm, " idle"}, busy1, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic job2(input int len, input string nm);
    int ptr = 0, reads = 0, k = 0, cyc = 0;
    bit finished = 0, rd, acc, exp_v;
    data.delete();
    for (int i = 0; i < exp_reads(len, 2) * 2 + 4; i++) data.push_back(BITS'(i + 1));
    start2 = 1'b1; len2 = len[3:0];
    @(posedge clk); #1 start2 = 1'b0;
    while (cyc < 200) begin
      bus2.buf_valid = (ptr + 2 <= data.size());
      bus2.buf_dout  = bus2.buf_valid ? {data[ptr + 1], data[ptr]} : '0;
      bus2.win_ready = 1'b1;
      @(negedge clk);
      exp_v = (avail(reads, 2) > k) && (k < len);
      chk({nm, " win_valid"}, bus2.win_valid, exp_v);
      chk({nm, " rd_en"}, bus2.buf_read_en, bus2.buf_valid && !exp_v && reads < exp_reads(len, 2));
      if (exp_v) chk({nm, " win_data"}, bus2.win_data, exp_win(k, 2));
      chk({nm, " done"}, done2, k == len);
      if (k == len) begin finished = 1; break; end
      rd  = bus2.buf_read_en;
      acc = bus2.win_valid && bus2.win_ready;
      @(posedge clk); #1;
      if (rd) begin ptr += 2; reads++; end
      if (acc) k++;
      cyc++;
    end
    if (!finished) chk({nm, " timeout"}, 1'b0, 1'b1);
    chk({nm, " reads"}, reads, exp_reads(len, 2));
    @(posedge clk); #1 bus2.buf_valid = 1'b0;
    @(negedge clk);
    chk({nm, " done_low"}, done2, 1'b0);
    chk({nm, " idle"}, busy2, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic rst_in_present();
    int cyc = 0;
    data.delete();
    for (int i = 0; i < 8; i++) data.push_back(BITS'(16'h1000 + i));
    start1 = 1'b1; len1 = 16'd3; bus1.win_ready = 1'b0;
    @(posedge clk); #1 start1 = 1'b0;
    bus1.buf_valid = 1'b1;
    while (!bus1.win_valid && cyc < 20) begin
      bus1.buf_dout = data[cyc % 8];
      @(posedge clk); #1 cyc++;
    end
    chk("rstp reached_present", bus1.win_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rstp win_valid", bus1.win_valid, 1'b0);
    chk("rstp busy", busy1, 1'b0);
    chk("rstp win_data", bus1.win_data, 64'h0);
    chk("rstp rd_en", bus1.buf_read_en, 1'b0);
    bus1.buf_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0; len1 = '0; start2 = 1'b0; len2 = '0;
    bus1.buf_valid = 1'b1; bus1.buf_dout = 16'hffff; bus1.win_ready = 1'b0;
    bus2.buf_valid = 1'b0; bus2.buf_dout = '0;       bus2.win_ready = 1'b0;
    @(negedge clk);
    chk("reset win_valid", bus1.win_valid, 1'b0);
    chk("reset rd_en", bus1.buf_read_en, 1'b0);
    chk("reset busy", busy1, 1'b0);
    chk("reset done", done1, 1'b0);
    chk("reset win_data", bus1.win_data, 64'h0);
    @(posedge clk); #1 rst = 1'b0; bus1.buf_valid = 1'b0;
    @(posedge clk); #1;

    job1(2, 100, 100, 16'h0, 0, 0, -1, 1, "basic");
    job1(3, 100, 100, 16'h0, 0, 5, -1, 0, "backpressure");
    job1(1, 100, 100, 16'h0059, 7, 0, -1, 2, "starved");
    job1(0, 100, 100, 16'h0, 0, 0, -1, 0, "len0");
    job1(4, 70, 60, 16'h0, 0, 0, 3, 0, "restart");
    for (int i = 0; i < 6; i++)
      job1($urandom_range(1, 5), $urandom_range(30, 100), $urandom_range(30, 100),
           16'h0, 0, 0, -1, 0, "random");
    rst_in_present();
    job1(1, 100, 100, 16'h0, 0, 0, -1, 1, "after_rst");
    job2(1, "par_read");
    job2(15, "max_len");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
